// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipeline: SR/Cause/EPC/PRId, exception/interrupt
// arbitration, mfc0 read port, mtc0 write port and eret handling.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL     = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic        eret_M,
    input  logic [5:0]  HWInt,
    output logic [31:0] DOut,
    output logic [31:0] EPC_out,
    output logic [31:0] HandlerPC,
    output logic        IntReq
);

    // EXL is the handler state: StInHandler masks every request (no nesting).
    typedef enum logic {StNormal, StInHandler} state_e;

    state_e      state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [29:0] epc_q, epc_d;   // word address; EPC[1:0] are always zero

    logic        exl;
    logic        int_irq;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    // Only IM/EXL/IE of SR and the word part of EPC are writable.
    logic unused_bits;
    assign unused_bits = ^{DIn[31:16], DIn[9:2], PC_M[1:0]};

    // Request arbitration and register views.
    always_comb begin
        exl       = (state_q == StInHandler);
        int_irq   = (|(HWInt & im_q)) & ie_q & ~exl;
        exc_req   = (ExcCode_M != 5'd0) & ~exl;
        IntReq    = int_irq | exc_req;
        sr_val    = {16'b0, im_q, 8'b0, exl, ie_q};
        cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
        epc_val   = {epc_q, 2'b00};
        EPC_out   = epc_val;
        HandlerPC = HANDLER_ADDR;
    end

    // mfc0 read port; no bypass of a same-cycle mtc0.
    always_comb begin
        DOut = 32'b0;
        case (A1)
            5'd12:   DOut = sr_val;
            5'd13:   DOut = cause_val;
            5'd14:   DOut = epc_val;
            5'd15:   DOut = PRID_VAL;
            default: DOut = 32'b0;
        endcase
    end

    // Next state: exception entry overrides mtc0/eret; eret wins EXL over a same-cycle mtc0.
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (IntReq) begin
            state_d    = StInHandler;
            bd_d       = BD_M;
            exc_code_d = int_irq ? 5'd0 : ExcCode_M;
            // Delay-slot victims restart at the branch; wraps modulo 2^32.
            epc_d      = PC_M[31:2] - {29'b0, BD_M};
        end else begin
            if (WE) begin
                case (A2)
                    5'd12: begin
                        im_d    = DIn[15:10];
                        ie_d    = DIn[0];
                        state_d = DIn[1] ? StInHandler : StNormal;
                    end
                    5'd14:   epc_d = DIn[31:2];
                    default: ;
                endcase
            end
            if (eret_M) begin
                state_d = StNormal;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StNormal;
            im_q       <= 6'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'b0;
            exc_code_q <= 5'b0;
            epc_q      <= 30'b0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// compared against a word-level model of the CP0 registers.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;
    localparam logic [31:0] HADDR = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCode_M;
    logic [31:0] DIn, PC_M;
    logic        WE, BD_M, eret_M;
    logic [5:0]  HWInt;
    logic [31:0] DOut, EPC_out, HandlerPC;
    logic        IntReq;

    int n_total = 0;
    int n_bad = 0;

    // Reference model: whole architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC_M      (PC_M),
        .BD_M      (BD_M),
        .ExcCode_M (ExcCode_M),
        .eret_M    (eret_M),
        .HWInt     (HWInt),
        .DOut      (DOut),
        .EPC_out   (EPC_out),
        .HandlerPC (HandlerPC),
        .IntReq    (IntReq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_irq();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_irq() || ((ExcCode_M != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic m_edge();
        logic irq, req;
        logic [31:0] pc_al;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            return;
        end
        irq = m_irq();
        req = m_req();
        pc_al = PC_M & 32'hFFFF_FFFC;
        if (req) begin
            m_sr = m_sr | 32'h2;
            m_cause = (BD_M ? 32'h8000_0000 : 32'h0) | (32'(HWInt) << 10)
                      | (irq ? 32'h0 : (32'(ExcCode_M) << 2));
            m_epc = BD_M ? pc_al - 32'd4 : pc_al;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
            if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
            if (WE && A2 == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
            if (eret_M) m_sr = m_sr & ~32'h2;
        end
    endtask

    // Check combinational outputs mid-cycle, then advance one edge.
    task automatic cycle();
        @(negedge clk);
        check("IntReq", {31'b0, IntReq}, {31'b0, m_req()});
        check("DOut", DOut, m_read(A1));
        check("EPC_out", EPC_out, m_epc);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic idle();
        WE = 0; eret_M = 0; ExcCode_M = 0; BD_M = 0; A2 = 0; DIn = 0;
    endtask

    initial begin
        m_sr = 32'hx; m_cause = 32'hx; m_epc = 32'hx;
        reset = 1; A1 = 0; PC_M = 32'h3000; HWInt = 0;
        idle();
        cycle();
        cycle();
        reset = 0;

        // T1: reset values
        peek(5'd12, "t1_sr", 32'h0);
        peek(5'd13, "t1_cause", 32'h0);
        peek(5'd14, "t1_epc", 32'h0);
        peek(5'd15, "t1_prid", PRID);
        check("t1_intreq", {31'b0, IntReq}, 32'h0);
        check("handler_pc", HandlerPC, HADDR);

        // T2: enable IM0/IE, then raise HWInt0
        WE = 1; A2 = 12; DIn = 32'h0000_0401;
        cycle();
        idle(); HWInt = 6'b000001; PC_M = 32'h0000_3010;
        #1; check("t2_intreq", {31'b0, IntReq}, 32'h1);
        cycle();
        peek(5'd13, "t2_cause", 32'h0000_0400);
        peek(5'd12, "t2_sr", 32'h0000_0403);
        check("t2_epc", EPC_out, 32'h0000_3010);
        check("t2_masked", {31'b0, IntReq}, 32'h0);
        cycle();

        // T3: RI in delay slot; concurrent mtc0 EPC dropped
        HWInt = 0; eret_M = 1;
        cycle();
        idle(); ExcCode_M = 5'd10; BD_M = 1; PC_M = 32'h0000_3024;
        WE = 1; A2 = 14; DIn = 32'h0000_1234;
        cycle();
        idle();
        peek(5'd14, "t3_epc", 32'h0000_3020);
        peek(5'd13, "t3_cause", 32'h8000_0028);

        // T4: interrupt beats simultaneous Ov
        eret_M = 1;
        cycle();
        idle(); HWInt = 6'b000001; ExcCode_M = 5'd12; PC_M = 32'h0000_3040;
        cycle();
        idle();
        peek(5'd13, "t4_cause", 32'h0000_0400);

        // T5: eret with pending interrupt, then re-entry with new EPC
        eret_M = 1; PC_M = 32'h0000_3050;
        cycle();
        idle(); PC_M = 32'h0000_3060;
        #1; check("t5_intreq", {31'b0, IntReq}, 32'h1);
        cycle();
        check("t5_epc", EPC_out, 32'h0000_3060);

        // T6: Cause read-only, EPC write aligned
        HWInt = 0; eret_M = 1;
        cycle();
        idle(); WE = 1; A2 = 13; DIn = 32'hFFFF_FFFF;
        cycle();
        peek(5'd13, "t6_cause", 32'h0);
        A2 = 14; DIn = 32'h0000_3007;
        cycle();
        idle();
        peek(5'd14, "t6_epc", 32'h0000_3004);

        // EPC wrap: PC 0 in a delay slot
        ExcCode_M = 5'd4; BD_M = 1; PC_M = 32'h0;
        cycle();
        idle();
        check("wrap_epc", EPC_out, 32'hFFFF_FFFC);

        // Reset mid-handler clears state and drops IntReq
        reset = 1; HWInt = 6'h3F;
        cycle();
        reset = 0; HWInt = 0;
        check("rst_epc", EPC_out, 32'h0);
        peek(5'd12, "rst_sr", 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int k;
            reset = ($urandom_range(0, 59) == 0);
            k = $urandom_range(0, 4);
            A1 = (k == 4) ? 5'($urandom) : 5'(12 + k);
            k = $urandom_range(0, 4);
            A2 = (k == 4) ? 5'($urandom) : 5'(12 + k);
            DIn = $urandom;
            WE = ($urandom_range(0, 3) == 0);
            PC_M = $urandom;
            BD_M = 1'($urandom);
            ExcCode_M = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            eret_M = ($urandom_range(0, 5) == 0);
            HWInt = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
